word_packer: RTL and testbench
==============================

WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 Parameter DATA_W, default 32, width of one input word; output width is 2*DATA_W.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0, takes effect immediately regardless of clock.
REQ-004 in_valid  input  1  upstream word present (driven by FIFO output side).
REQ-005 in_ready  output  1  block accepts a word this cycle.
REQ-006 packet_in  input  DATA_W  input word.
REQ-007 in_last  input  1  accepted word ends the current packet.
REQ-008 out_valid  output  1  packed output present.
REQ-009 out_ready  input  1  downstream accepts the output this cycle.
REQ-010 packet_out  output  2*DATA_W  packed data; lane 0 = bits [DATA_W-1:0], lane 1 = upper half.
REQ-011 out_keep  output  2  per-lane valid mask.
REQ-012 out_last  output  1  output beat ends the packet.

Function
REQ-013 Input transfer SHALL occur iff in_valid && in_ready at a rising clock edge; output transfer iff out_valid && out_ready.
REQ-014 in_ready SHALL equal !out_valid || out_ready (combinational; no other dependency).
REQ-015 State: half flag plus lane-0 holding register; states EMPTY (half=0) and HALF (half=1).
REQ-016 EMPTY, transfer, in_last=0: SHALL store packet_in in holding register, go HALF, emit nothing.
REQ-017 EMPTY, transfer, in_last=1: SHALL load output with packet_out={0, packet_in}, out_keep=2'b01, out_last=1, stay EMPTY.
REQ-018 HALF, transfer: SHALL load output with packet_out={packet_in, holding}, out_keep=2'b11, out_last=in_last, go EMPTY.
REQ-019 Output register load SHALL set out_valid=1 on the next cycle; latency = 1 cycle from the completing input transfer.
REQ-020 Output transfer with no simultaneous load SHALL clear out_valid next cycle; output transfer and load in the same cycle SHALL replace contents with out_valid staying 1 (no bubble).
REQ-021 While out_valid && !out_ready, packet_out/out_keep/out_last SHALL hold stable and in_ready SHALL be 0.
REQ-022 Unused upper lane (out_keep=2'b01) SHALL be driven 0.
REQ-023 Sustained throughput SHALL be one input word per cycle when out_ready=1.
REQ-024 Holding register and half flag SHALL NOT change without an input transfer.

Reset
REQ-025 While reset=0: out_valid=0, out_keep=0, out_last=0, packet_out=0, half=0, holding register=0.
REQ-026 in_ready SHALL be 1 during reset (per REQ-014); transfers during reset SHALL be ignored.
REQ-027 Reset mid-packet SHALL discard the held half-word and any pending output; first word after release starts a new packet in lane 0.

Verification
REQ-028 Words A=0x11111111, B=0x22222222 (last on B), out_ready=1 -> one beat packet_out=0x2222222211111111, keep=11, last=1, one cycle after B accepted.
REQ-029 Single word C=0x33333333 with in_last=1 -> beat packet_out=0x0000000033333333, keep=01, last=1.
REQ-030 Three words D,E,F (last on F) -> beats {E,D} keep=11 last=0, then {0,F} keep=01 last=1.
REQ-031 Output pending, out_ready=0 for 5 cycles -> in_ready=0, outputs stable all 5 cycles; in_valid held data accepted after out_ready=1.
REQ-032 Continuous 8-word stream, out_ready=1 -> in_ready never 0, four back-to-back beats with no idle cycle between completions.
REQ-033 reset=0 asserted between first and second word of a pair -> held word lost; next pair after release packs correctly with keep=11.

Source files
------------

// File: rtl/word_packer.sv
// word_packer: packs pairs of DATA_W input words into one 2*DATA_W output beat.
// Ports: clock, reset (async active-low), in_* upstream handshake, out_* packed beat.
module word_packer #(
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   packet_in,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] packet_out,
  output logic [1:0]          out_keep,
  output logic                out_last
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HALF  = 1'b1;

  logic [0:0]          half_q, half_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                ov_q, ov_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic [1:0]          keep_q, keep_d;
  logic                last_q, last_d;

  logic in_xfer;
  logic out_xfer;
  logic load;

  // A new word can enter whenever the output slot is free or draining.
  assign in_ready = !ov_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = ov_q && out_ready;

  always_comb begin
    half_d = half_q;
    hold_d = hold_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    load   = 1'b0;
    if (in_xfer) begin
      unique case (half_q)
        ST_EMPTY: begin
          if (in_last) begin
            load   = 1'b1;
            data_d = {{DATA_W{1'b0}}, packet_in};
            keep_d = 2'b01;
            last_d = 1'b1;
          end else begin
            hold_d = packet_in;
            half_d = ST_HALF;
          end
        end
        ST_HALF: begin
          load   = 1'b1;
          data_d = {packet_in, hold_q};
          keep_d = 2'b11;
          last_d = in_last;
          half_d = ST_EMPTY;
        end
        default: half_d = ST_EMPTY;
      endcase
    end
  end

  // A load wins over a drain so back-to-back beats never bubble.
  always_comb begin
    ov_d = ov_q;
    if (load)
      ov_d = 1'b1;
    else if (out_xfer)
      ov_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      half_q <= ST_EMPTY;
      hold_q <= '0;
      ov_q   <= 1'b0;
      data_q <= '0;
      keep_q <= 2'b00;
      last_q <= 1'b0;
    end else begin
      half_q <= half_d;
      hold_q <= hold_d;
      ov_q   <= ov_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end
  end

  assign out_valid  = ov_q;
  assign packet_out = data_q;
  assign out_keep   = keep_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed self-checking bench for word_packer.
// Drives inputs #1 after each rising edge and checks there as well.
module tb_word_packer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] packet_in;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] packet_out;
  logic [1:0]  out_keep;
  logic        out_last;

  int checks;
  int failures;
  int beats;

  word_packer #(.DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .packet_in  (packet_in),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .packet_out (packet_out),
    .out_keep   (out_keep),
    .out_last   (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d,
                          input logic [1:0] k, input logic l);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_data"}, packet_out, d);
    chk({tag, "_keep"}, {62'd0, out_keep}, {62'd0, k});
    chk({tag, "_last"}, {63'd0, out_last}, {63'd0, l});
  endtask

  task automatic put(input logic [31:0] d, input logic l);
    in_valid  = 1'b1;
    packet_in = d;
    in_last   = l;
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] w [8];
    checks    = 0;
    failures  = 0;
    beats     = 0;
    reset     = 1'b0;
    out_ready = 1'b1;
    put(32'hDEADBEEF, 1'b1);
    tick();
    tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", packet_out, 64'd0);
    chk("rst_keep", {62'd0, out_keep}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    chk("rst_ignored", {63'd0, out_valid}, 64'd0);

    // A,B pair
    put(32'h11111111, 1'b0);
    tick();
    chk("ab_half", {63'd0, out_valid}, 64'd0);
    put(32'h22222222, 1'b1);
    tick();
    chk_beat("ab", 64'h2222222211111111, 2'b11, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("ab_drain", {63'd0, out_valid}, 64'd0);

    // single C
    put(32'h33333333, 1'b1);
    tick();
    chk_beat("c", 64'h0000000033333333, 2'b01, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("c_drain", {63'd0, out_valid}, 64'd0);

    // D,E,F
    put(32'h44444444, 1'b0);
    tick();
    chk("d_half", {63'd0, out_valid}, 64'd0);
    put(32'h55555555, 1'b0);
    tick();
    chk_beat("ed", 64'h5555555544444444, 2'b11, 1'b0);
    put(32'h66666666, 1'b1);
    tick();
    chk_beat("f", 64'h0000000066666666, 2'b01, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("f_drain", {63'd0, out_valid}, 64'd0);

    // backpressure for 5 cycles
    put(32'h77777777, 1'b1);
    tick();
    held = 64'h0000000077777777;
    chk_beat("g", held, 2'b01, 1'b1);
    out_ready = 1'b0;
    put(32'h88888888, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      chk_beat("bp_hold", held, 2'b01, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {63'd0, in_ready}, 64'd1);
    tick();
    chk("h_half", {63'd0, out_valid}, 64'd0);
    put(32'h99999999, 1'b1);
    tick();
    chk_beat("ih", 64'h9999999988888888, 2'b11, 1'b1);
    in_valid = 1'b0;
    tick();

    // 8-word stream
    for (int i = 0; i < 8; i++) w[i] = 32'hA0000000 + 32'(i);
    for (int i = 0; i < 8; i++) begin
      put(w[i], i == 7);
      #1;
      chk("str_in_ready", {63'd0, in_ready}, 64'd1);
      tick();
      if (i % 2 == 1) begin
        chk_beat("str", {w[i], w[i-1]}, 2'b11, i == 7);
        beats++;
      end else begin
        chk("str_gap", {63'd0, out_valid}, 64'd0);
      end
    end
    in_valid = 1'b0;
    chk("str_beats", 64'(beats), 64'd4);
    tick();
    chk("str_drain", {63'd0, out_valid}, 64'd0);

    // reset with a stalled beat pending
    out_ready = 1'b0;
    put(32'hBBBBBBBB, 1'b1);
    tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("rp_valid", {63'd0, out_valid}, 64'd0);
    chk("rp_data", packet_out, 64'd0);
    chk("rp_keep", {62'd0, out_keep}, 64'd0);
    chk("rp_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();

    // reset between the two words of a pair
    put(32'hCCCCCCCC, 1'b0);
    tick();
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    put(32'hDDDDDDDD, 1'b0);
    tick();
    chk("mr_half", {63'd0, out_valid}, 64'd0);
    put(32'hEEEEEEEE, 1'b1);
    tick();
    chk_beat("mr", 64'hEEEEEEEEDDDDDDDD, 2'b11, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("mr_drain", {63'd0, out_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
